// File: rtl/opb_register_simulink2ppc_sync.sv
// ---------------------------------------------------------------------------
// opb_register_simulink2ppc_sync
//
// Read-back register carrying a 32-bit word from Simulink fabric logic to the
// PowerPC over OPB. The fabric presents user_data_in with a user_valid strobe;
// the word is captured and returned to the processor by a single-wait-state
// OPB slave. Everything runs on OPB_Clk, so the fabric side must be
// synchronous to OPB_Clk.
//
// Register map (byte offset inside the 256-byte window):
//   0x0  DATA    last captured word (reading it clears "fresh")
//   0x4  STATUS  [31] overflow (sticky), [30] fresh, [29:16] 0, [15:0] count
//                any write clears overflow
//   else         reads 0, writes acknowledged and discarded
//
// Build option:
//   OPB_S2P_STATUS_EN  when defined, the STATUS register with its count,
//                      fresh and overflow flops is built. When undefined,
//                      offset 0x4 behaves like any unmapped offset.
//
// Ports:
//   OPB_Clk, OPB_Rst_n       clock, asynchronous active-low reset
//   OPB_ABus/BE/DBus/RNW     OPB master request (BE, DBus, seqAddr unused:
//   OPB_select/seqAddr       reads ignore BE, all writes discard data)
//   Sl_DBus, Sl_xferAck      read data (zero outside the ack cycle), ack
//   Sl_errAck/retry/toutSup  tied 0
//   user_data_in, user_valid fabric word and capture strobe
//
// OPB buses use IBM bit order ([0] is the MSB): Sl_DBus[i] = reg[31-i].
// ---------------------------------------------------------------------------
module opb_register_simulink2ppc_sync #(
  parameter int                    C_OPB_AWIDTH = 32,
  parameter int                    C_OPB_DWIDTH = 32,
  parameter logic [C_OPB_AWIDTH-1:0] C_BASEADDR = 32'hFFFF_FFFF,
  parameter logic [C_OPB_AWIDTH-1:0] C_HIGHADDR = 32'h0000_0000,
  parameter                        C_FAMILY     = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_valid
);

  // Target family is informational only.
  localparam int unused_family_bits = $bits(C_FAMILY);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Plain [N:0] copy of the address so offsets read naturally (bit 2 = 0x4).
  logic [C_OPB_AWIDTH-1:0] addr;
  assign addr = OPB_ABus;

  logic hit;
  logic start;
  logic sel_data;
  logic data_rd;

  assign hit      = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  // A request is only taken in IDLE; a select held through ACK is simply
  // re-taken on the following cycle.
  assign start    = (state_q == IDLE) && hit;
  assign sel_data = (addr[7:2] == 6'd0);
  assign data_rd  = start && OPB_RNW && sel_data;

  logic unused_inputs;
  assign unused_inputs = ^{OPB_BE, OPB_DBus, OPB_seqAddr, addr[1:0]};

  // -------------------------------------------------------------------------
  // Transfer FSM
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults first so every path assigns state_d and no latch forms.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hit) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (!OPB_Rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // Captured word
  // -------------------------------------------------------------------------
  logic [31:0] data_q;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n)      data_q <= '0;
    else if (user_valid) data_q <= user_data_in;
  end

  // -------------------------------------------------------------------------
  // Status: capture count, freshness, overrun
  // -------------------------------------------------------------------------
  logic [31:0] rd_word;

`ifdef OPB_S2P_STATUS_EN
  logic [15:0] count_q;
  logic        fresh_q;
  logic        overflow_q;
  logic        sel_status;
  logic        status_clr;
  logic        overflow_set;

  assign sel_status   = (addr[7:2] == 6'd1);
  assign status_clr   = start && !OPB_RNW && sel_status;
  // A capture that lands on the same edge as a DATA read is not an overrun:
  // the processor is consuming the previous word at that very edge.
  assign overflow_set = user_valid && fresh_q && !data_rd;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      count_q    <= '0;
      fresh_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (user_valid) count_q <= count_q + 16'd1;

      // Capture wins over the read-clear so the new word stays fresh.
      if (user_valid)   fresh_q <= 1'b1;
      else if (data_rd) fresh_q <= 1'b0;

      // Set wins over the write-clear so no overrun is silently lost.
      if (overflow_set)    overflow_q <= 1'b1;
      else if (status_clr) overflow_q <= 1'b0;
    end
  end

  always_comb begin
    rd_word = '0;
    if (sel_data)        rd_word = data_q;
    else if (sel_status) rd_word = {overflow_q, fresh_q, 14'd0, count_q};
  end
`else
  always_comb begin
    rd_word = '0;
    if (sel_data) rd_word = data_q;
  end
`endif

  // -------------------------------------------------------------------------
  // Read data: registered at the hit edge, so it reflects register contents
  // before that edge's updates, and is zero in every non-ack cycle.
  // -------------------------------------------------------------------------
  logic [C_OPB_DWIDTH-1:0] dbus_q;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n)             dbus_q <= '0;
    else if (start && OPB_RNW)  dbus_q <= rd_word;
    else                        dbus_q <= '0;
  end

  assign Sl_DBus    = dbus_q;
  assign Sl_xferAck = (state_q == ACK);
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_simulink2ppc_sync.sv
// ---------------------------------------------------------------------------
// Directed testbench for opb_register_simulink2ppc_sync. Inputs change and
// outputs are sampled on the falling edge; the DUT acts on the rising edge.
// STATUS expectations collapse to zero when OPB_S2P_STATUS_EN is undefined.
// ---------------------------------------------------------------------------
module tb_opb_register_simulink2ppc_sync;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] HIGH   = 32'h4000_00FF;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'h4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [0:31] abus = '0;
  logic [0:3]  be = 4'hF;
  logic [0:31] wdbus = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seq_addr = 1'b0;
  logic [0:31] dbus;
  logic        ack;
  logic        err_ack;
  logic        retry;
  logic        tout_sup;
  logic [31:0] user_data = '0;
  logic        user_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  opb_register_simulink2ppc_sync #(
    .C_BASEADDR (BASE),
    .C_HIGHADDR (HIGH)
  ) dut (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .OPB_ABus     (abus),
    .OPB_BE       (be),
    .OPB_DBus     (wdbus),
    .OPB_RNW      (rnw),
    .OPB_select   (sel),
    .OPB_seqAddr  (seq_addr),
    .Sl_DBus      (dbus),
    .Sl_xferAck   (ack),
    .Sl_errAck    (err_ack),
    .Sl_retry     (retry),
    .Sl_toutSup   (tout_sup),
    .user_data_in (user_data),
    .user_valid   (user_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] st(input logic ovf, input logic fr, input logic [15:0] cnt);
`ifdef OPB_S2P_STATUS_EN
    return {ovf, fr, 14'd0, cnt};
`else
    return 32'h0 & {ovf, fr, 14'd0, cnt};
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dbus", dbus, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic capture(input logic [31:0] v);
    @(negedge clk);
    user_valid = 1'b1;
    user_data  = v;
    @(negedge clk);
    user_valid = 1'b0;
  endtask

  // One OPB transfer, optionally with a capture on the same edge as the hit.
  // lat = cycles from the hit edge to the ack sample (0 expected), -1 if none.
  task automatic xfer(input logic [31:0] a, input logic r, input logic cap,
                      input logic [31:0] cap_d, output logic [31:0] d, output int lat);
    @(negedge clk);
    sel = 1'b1; abus = a; rnw = r; wdbus = 32'hA5A5_5A5A;
    user_valid = cap; user_data = cap_d;
    lat = -1; d = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      user_valid = 1'b0;
      if (ack) begin
        lat = i; d = dbus; sel = 1'b0;
        break;
      end
    end
    sel = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d; int lat;
    xfer(a, 1'b1, 1'b0, '0, d, lat);
    check({tag, "_lat"}, lat, 32'd0);
    check(tag, d, exp);
  endtask

  task automatic wr(input string tag, input logic [31:0] a);
    logic [31:0] d; int lat;
    xfer(a, 1'b0, 1'b0, '0, d, lat);
    check({tag, "_lat"}, lat, 32'd0);
    check({tag, "_dbus"}, d, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int lat;

    // Reset state
    do_reset();
    rd("t1_data", A_DATA, 32'h0);
    rd("t1_stat", A_STAT, st(0, 0, 16'd0));

    // Single capture and read-back, freshness clears on DATA read
    capture(32'hDEAD_BEEF);
    rd("t2_stat_pre", A_STAT, st(0, 1, 16'd1));
    rd("t2_data", A_DATA, 32'hDEAD_BEEF);
    rd("t2_stat_post", A_STAT, st(0, 0, 16'd1));

    // Overrun, write-clear, discarded writes
    do_reset();
    capture(32'h1);
    capture(32'h2);
    rd("t3_stat_ovf", A_STAT, st(1, 1, 16'd2));
    wr("t3_wr_stat", A_STAT);
    rd("t3_stat_clr", A_STAT, st(0, 1, 16'd2));
    wr("t3_wr_data", A_DATA);
    rd("t3_data", A_DATA, 32'h2);
    rd("t3_stat_rd", A_STAT, st(0, 0, 16'd2));

    // Overflow set and STATUS write-clear on the same edge: set wins
    capture(32'h3);
    xfer(A_STAT, 1'b0, 1'b1, 32'h4, d, lat);
    check("t3b_lat", lat, 32'd0);
    rd("t3b_stat", A_STAT, st(1, 1, 16'd4));
    rd("t3b_data", A_DATA, 32'h4);

    // Capture on the same edge as a DATA read returns the old word
    do_reset();
    capture(32'h11);
    rd("t4_stat_pre", A_STAT, st(0, 1, 16'd1));
    xfer(A_DATA, 1'b1, 1'b1, 32'h55, d, lat);
    check("t4_sim_lat", lat, 32'd0);
    check("t4_sim_data", d, 32'h11);
    rd("t4_stat_sim", A_STAT, st(0, 1, 16'd2));
    rd("t4_data_new", A_DATA, 32'h55);
    rd("t4_stat_post", A_STAT, st(0, 0, 16'd2));

    // Unmapped offsets read zero
    rd("t4_off8", BASE + 32'h8, 32'h0);
    rd("t4_offfc", BASE + 32'hFC, 32'h0);

    // Select held on DATA: ack every second cycle, bus zero between acks
    @(negedge clk);
    sel = 1'b1; abus = A_DATA; rnw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t5_hold_ack%0d", i), {31'd0, ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check($sformatf("t5_hold_dbus%0d", i), dbus, (i % 2 == 1) ? 32'h55 : 32'h0);
      @(negedge clk);
    end
    sel = 1'b0;

    // Outside the window: never acknowledged
    xfer(HIGH + 32'h1, 1'b1, 1'b0, '0, d, lat);
    check("t5_above_lat", lat, 32'hFFFF_FFFF);
    xfer(BASE - 32'h4, 1'b1, 1'b0, '0, d, lat);
    check("t5_below_lat", lat, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of an ack
    capture(32'hA5A5_0001);
    @(negedge clk);
    sel = 1'b1; abus = A_DATA; rnw = 1'b1;
    @(posedge clk);
    #1;
    check("t6_ack_before", {31'd0, ack}, 32'd1);
    sel = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t6_ack_async", {31'd0, ack}, 32'd0);
    check("t6_dbus_async", dbus, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd("t6_data", A_DATA, 32'h0);
    rd("t6_stat", A_STAT, st(0, 0, 16'd0));

    // Count wrap: 65535 captures, then one more
    do_reset();
    @(negedge clk);
    user_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      user_data = i;
      @(negedge clk);
    end
    user_valid = 1'b0;
    rd("t7_stat_ffff", A_STAT, st(1, 1, 16'hFFFF));
    capture(32'h0000_FFFF);
    rd("t7_stat_wrap", A_STAT, st(1, 1, 16'h0000));
    rd("t7_data", A_DATA, 32'h0000_FFFF);

    // Tied-off responses
    check("tie_err", {31'd0, err_ack}, 32'd0);
    check("tie_retry", {31'd0, retry}, 32'd0);
    check("tie_tout", {31'd0, tout_sup}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/opb_register_simulink2ppc_sync.md
# opb_register_simulink2ppc_sync

Read-back register bridging fabric data to the PowerPC over OPB: the opposite direction of the PPC-to-Simulink control registers. Simulink logic presents a 32-bit word with a valid strobe; the block captures it, tracks freshness and overrun, and returns it to the processor through a single-wait-state OPB slave. The block runs on one clock (OPB_Clk), so user logic must be synchronous to OPB_Clk.

## Interface
- C_BASEADDR, 32'hFFFFFFFF, first byte address of the 256-byte window
- C_HIGHADDR, 32'h00000000, last byte address of the window
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width
- C_FAMILY, "virtex5", target family (informational)

- OPB_Clk  in  1  sole clock; all logic rising-edge
- OPB_Rst_n  in  1  reset, asynchronous, active-low
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables (ignored for reads)
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  sequential hint (ignored)
- Sl_DBus  out  [0:31]  read data; zero unless Sl_xferAck
- Sl_xferAck  out  1  transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
- user_data_in  in  [31:0]  word from fabric
- user_valid  in  1  capture strobe

## Operation
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Offset = OPB_ABus[29] ... decoded from byte offset bits [2] of address in little sense: offset 0x0 = DATA, 0x4 = STATUS, others read 0.
- Bit mapping: Sl_DBus[i] = reg[31-i].
- Capture: user_valid=1 -> data_reg <= user_data_in; count <= count+1 (16-bit, wraps 0xFFFF->0x0000); fresh <= 1; if fresh already 1, overflow <= 1.
- DATA read acknowledged -> fresh <= 0.
- STATUS: [31] overflow (sticky), [30] fresh, [29:16] 0, [15:0] count.
- Write to STATUS (any BE) clears overflow; all other writes acknowledged and discarded.
- FSM: IDLE -> ACK on hit; ACK -> IDLE unconditionally. No hit in ACK, so a held select is re-acknowledged every second cycle.

## Timing
- Reset: Sl_DBus=0, Sl_xferAck=0, data_reg=0, count=0, fresh=0, overflow=0, state=IDLE.
- Read latency: hit sampled at edge N; Sl_xferAck=1 and Sl_DBus valid for exactly cycle N..N+1 (one cycle). Data reflects register contents at edge N.
- Capture latency: user_valid sampled at edge N; value readable by a hit sampled at edge N+1 or later.
- Simultaneous capture and DATA read at same edge: read returns old word; fresh ends 1; overflow unchanged.
- Simultaneous overflow-set and STATUS write-clear: set wins.
- Master drops select during ACK: ack still completes that cycle (OPB timeout rules tolerate it).
- Reset mid-transfer: xferAck drops asynchronously; captured state lost.

## Configuration
- OPB_S2P_STATUS_EN defined: STATUS register, count, fresh, overflow implemented as above.
- Undefined: offset 0x4 reads 0, writes ignored; no count/fresh/overflow flops; DATA behaviour and timing unchanged.

## Test plan
- Reset then DATA read at 0x...00 -> xferAck 1 cycle after select, Sl_DBus=0x00000000; STATUS=0x00000000.
- user_valid with 0xDEADBEEF, read DATA -> Sl_DBus[0:31]=0xDEADBEEF; STATUS before read 0x40000001, after 0x00000001.
- Two captures (0x1, 0x2) no read -> STATUS 0xC0000002; write STATUS -> 0x40000002.
- Capture 0x55 same edge as DATA read of old 0x11 -> returns 0x11; next read returns 0x55.
- Select held 6 cycles on DATA -> xferAck pattern 0,1,0,1,0,1; Sl_DBus zero whenever xferAck=0; address outside window -> never ack.
- 65536 captures -> count wraps to 0x0000; assert OPB_Rst_n low mid-ACK -> Sl_xferAck falls without clock edge.
